// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, sequencer states and command record sizing
package alu_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_INC    = 3'b000,
    OP_DEC    = 3'b001,
    OP_INV    = 3'b010,
    OP_REDAND = 3'b011,
    OP_REDOR  = 3'b100,
    OP_TEMP0  = 3'b101,
    OP_TEMP1  = 3'b110,
    OP_NOP    = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } seq_state_e;

  // A queued command is {opcode, operand A, operand B}, opcode in the top bits.
  function automatic int cmd_rec_w(input int data_w);
    return OP_W + 2 * data_w;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - synchronous command FIFO with occupancy count
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int WIDTH = 35,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  // Overflow and underflow requests are dropped here so the pointers can never cross.
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem[rd_ptr];

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - queues ALU commands, issues one at a time, holds results
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic [DATA_W-1:0] alu_in0,
  output logic [DATA_W-1:0] alu_in1,
  output logic [2:0]        alu_cmd,
  input  logic [DATA_W-1:0] alu_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [2:0]        res_op,
  output logic              res_zero
);

  localparam int REC_W = cmd_rec_w(DATA_W);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  seq_state_e       state_q;
  seq_state_e       state_d;
  logic [REC_W-1:0] push_rec;
  logic [REC_W-1:0] head_rec;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             capture;
  logic             release_res;

  // Ready depends only on the registered count, so a same-cycle pop never admits a push when full.
  assign cmd_ready = (fifo_count != CNT_FULL);
  assign fifo_push = cmd_valid && !fifo_full;
  assign push_rec  = {cmd_op, cmd_a, cmd_b};

  alu_cmd_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (push_rec),
    .pop       (fifo_pop),
    .pop_data  (head_rec),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus pop/capture/release strobes; a released result may pop the next command at once.
  always_comb begin
    state_d     = state_q;
    fifo_pop    = 1'b0;
    capture     = 1'b0;
    release_res = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        capture = 1'b1;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (res_valid && res_ready) begin
          release_res = 1'b1;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = ST_ISSUE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ALU operand/opcode registers; they keep the last issued command between pops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_in0 <= '0;
      alu_in1 <= '0;
      alu_cmd <= OP_NOP;
    end else if (fifo_pop) begin
      alu_cmd <= head_rec[REC_W-1 -: OP_W];
      alu_in0 <= head_rec[2*DATA_W-1 -: DATA_W];
      alu_in1 <= head_rec[DATA_W-1:0];
    end
  end

  // Result registers: loaded one cycle after issue, frozen until the downstream handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_op    <= OP_NOP;
      res_zero  <= 1'b0;
    end else if (capture) begin
      res_valid <= 1'b1;
      res_data  <= alu_out;
      res_op    <= alu_cmd;
      res_zero  <= (alu_out == '0);
    end else if (release_res) begin
      res_valid <= 1'b0;
    end
  end

endmodule
